// File: rtl/piano_pkg.sv
// Shared constants and types for the piano audio path: note indexing,
// oscillator half-periods and sample width.
package piano_pkg;

    localparam int NUM_NOTES  = 7;
    localparam int SAMPLE_W   = 24;
    localparam int CNT_W      = 17;
    localparam int REF_CLK_HZ = 50_000_000;

    typedef enum logic [2:0] {
        NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B
    } note_e;

    // Half-periods in cycles at REF_CLK_HZ, C4..B4.
    localparam logic [CNT_W-1:0] HALF_PERIOD [NUM_NOTES] = '{
        17'd95419, 17'd85034, 17'd75757, 17'd71633,
        17'd63775, 17'd56818, 17'd50607
    };

    // CLK_HZ / (2*f), truncated, for clocks other than the reference.
    function automatic logic [CNT_W-1:0] half_period(input int clk_hz, input int idx);
        int hz;
        case (idx)
            0:       hz = 262;
            1:       hz = 294;
            2:       hz = 330;
            3:       hz = 349;
            4:       hz = 392;
            5:       hz = 440;
            default: hz = 494;
        endcase
        return CNT_W'(clk_hz / (2 * hz));
    endfunction

endpackage

// File: rtl/square_osc.sv
// One square-wave note oscillator: free-runs while enabled, held at
// phase 0 with a cleared counter while disabled.
module square_osc
    import piano_pkg::*;
#(
    parameter logic [CNT_W-1:0] HALF      = 17'd95419,
    parameter int               AMPLITUDE = 1_048_576
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       en,
    output logic signed [SAMPLE_W-1:0] level
);

    localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(AMPLITUDE);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!en) begin
            // a released note always restarts from phase 0
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == HALF - 1'b1) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        level = '0;
        if (en)
            level = r_phase ? -AMP : AMP;
    end

endmodule

// File: rtl/note_tone_gen.sv
// Polyphonic square-wave tone generator: synchronises the note switches,
// mixes seven oscillators and emits samples at SAMPLE_HZ over valid/ready.
module note_tone_gen
    import piano_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 48_000,
    parameter int AMPLITUDE = 1_048_576
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       c_note,
    input  logic                       d_note,
    input  logic                       e_note,
    input  logic                       f_note,
    input  logic                       g_note,
    input  logic                       a_note,
    input  logic                       b_note,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       note_on,
    output logic                       overrun
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = $clog2(DIV);

    logic [NUM_NOTES-1:0]       w_notes;
    logic [NUM_NOTES-1:0]       r_sync1;
    logic [NUM_NOTES-1:0]       r_sync2;
    logic signed [SAMPLE_W-1:0] w_level [NUM_NOTES];
    logic signed [SAMPLE_W-1:0] w_mix;
    logic [DIV_W-1:0]           r_div;
    logic                       w_tick;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_valid;
    logic                       r_overrun;
    logic                       r_note_on;

    always_comb begin
        w_notes         = '0;
        w_notes[NOTE_C] = c_note;
        w_notes[NOTE_D] = d_note;
        w_notes[NOTE_E] = e_note;
        w_notes[NOTE_F] = f_note;
        w_notes[NOTE_G] = g_note;
        w_notes[NOTE_A] = a_note;
        w_notes[NOTE_B] = b_note;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_note_on <= 1'b0;
        end else begin
            r_sync1   <= w_notes;
            r_sync2   <= r_sync1;
            r_note_on <= |r_sync2;
        end
    end

    // The reference table is used verbatim at 50 MHz; other clocks derive it.
    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_osc
        localparam logic [CNT_W-1:0] HALF = (CLK_HZ == REF_CLK_HZ) ?
                                            HALF_PERIOD[gi] : half_period(CLK_HZ, gi);
        square_osc #(
            .HALF      (HALF),
            .AMPLITUDE (AMPLITUDE)
        ) u_osc (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .en       (r_sync2[gi]),
            .level    (w_level[gi])
        );
    end

    // 7*AMPLITUDE fits in 24 bits signed, so the plain sum never wraps.
    always_comb begin
        w_mix = '0;
        for (int i = 0; i < NUM_NOTES; i++)
            w_mix = w_mix + w_level[i];
    end

    assign w_tick = (r_div == DIV_W'(DIV - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    // A tick always wins over an accept; overrun only when an unread sample is lost.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_tick) begin
            r_sample <= w_mix;
            r_valid  <= 1'b1;
            if (r_valid && !sample_ready)
                r_overrun <= 1'b1;
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign note_on      = r_note_on;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen at a 5 MHz clock / 4800 Hz sample rate (DIV stays 1041,
// half-periods scale by 1/10) with a note-age model and directed scenarios.
module tb_note_tone_gen;

    localparam int CLK_HZ    = 5_000_000;
    localparam int SAMPLE_HZ = 4_800;
    localparam int AMP       = 1_048_576;
    localparam int DIV       = 1041;
    localparam int HALF_TB [7] = '{9541, 8503, 7575, 7163, 6377, 5681, 5060};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        notes = '0;
    logic              ready = 1'b1;
    logic signed [23:0] sample;
    logic              sample_valid;
    logic              note_on;
    logic              overrun;

    int n_vec = 0;
    int n_bad = 0;
    int e;

    always #5 clk = ~clk;

    note_tone_gen #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .AMPLITUDE (AMP)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .c_note       (notes[0]),
        .d_note       (notes[1]),
        .e_note       (notes[2]),
        .f_note       (notes[3]),
        .g_note       (notes[4]),
        .a_note       (notes[5]),
        .b_note       (notes[6]),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (ready),
        .note_on      (note_on),
        .overrun      (overrun)
    );

    // Model: each note's age = consecutive edges it has been seen enabled
    // (after two edges of switch delay); its sign is the parity of age/half.
    int       rel;
    bit [6:0] h1, h2;
    int       age [7];
    int       m_sample;
    bit       m_valid, m_ovr, m_on;

    function automatic int model_mix();
        int s;
        s = 0;
        for (int i = 0; i < 7; i++)
            if (h2[i])
                s += (((age[i] / HALF_TB[i]) % 2) == 1) ? -AMP : AMP;
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rel      <= 0;
            h1       <= '0;
            h2       <= '0;
            m_sample <= 0;
            m_valid  <= 1'b0;
            m_ovr    <= 1'b0;
            m_on     <= 1'b0;
            for (int i = 0; i < 7; i++) age[i] <= 0;
        end else begin
            rel <= rel + 1;
            if ((rel + 1) % DIV == 0) begin
                m_sample <= model_mix();
                m_valid  <= 1'b1;
                if (m_valid && !ready) m_ovr <= 1'b1;
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
            m_on <= |h2;
            for (int i = 0; i < 7; i++) age[i] <= h2[i] ? age[i] + 1 : 0;
            h2 <= h1;
            h1 <= notes;
        end
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_sample",  $signed(sample), m_sample);
            check("model_valid",   {31'd0, sample_valid}, {31'd0, m_valid});
            check("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("model_note_on", {31'd0, note_on}, {31'd0, m_on});
        end
    end

    // Returns the number of edges until sample_valid is seen, or -1.
    task automatic wait_valid(output int edges);
        edges = -1;
        for (int k = 1; k <= 2 * DIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, idle ticks with ready high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sample",  $signed(sample), 0);
        check("rst_valid",   {31'd0, sample_valid}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_note_on", {31'd0, note_on}, 0);
        @(posedge clk); #2 rst = 1'b0;
        wait_valid(e);
        check("first_valid_edge", e, DIV);
        check("idle_sample", $signed(sample), 0);
        check("idle_overrun", {31'd0, overrun}, 0);
        @(posedge clk); @(negedge clk);
        check("valid_drop", {31'd0, sample_valid}, 0);
        wait_valid(e);
        check("rerise_gap", 1 + e, DIV);

        // 2: C held
        @(posedge clk); #2 notes[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("note_on_edge2", {31'd0, note_on}, 0);
        @(posedge clk); @(negedge clk);
        check("note_on_edge3", {31'd0, note_on}, 1);
        wait_valid(e);
        check("c_first_pos", $signed(sample), AMP);
        repeat (HALF_TB[0] + 1100) @(posedge clk);
        wait_valid(e);
        check("c_neg_half", $signed(sample), -AMP);
        repeat (HALF_TB[0]) @(posedge clk);
        wait_valid(e);
        check("c_pos_period", $signed(sample), AMP);

        // 3: all seven pressed right after a tick
        notes = '0;
        wait_valid(e);
        notes = 7'h7F;
        wait_valid(e);
        check("all_first", $signed(sample), 7340032);
        repeat (4) wait_valid(e);
        check("all_b_flipped", $signed(sample), 5242880);

        // 4: ready low across two ticks
        check("ovr_before", {31'd0, overrun}, 0);
        ready = 1'b0;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        check("hold_valid", {31'd0, sample_valid}, 1);
        check("hold_sample", $signed(sample), 3145728);
        check("hold_overrun", {31'd0, overrun}, 1);
        ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("accept_valid", {31'd0, sample_valid}, 0);
        check("accept_overrun", {31'd0, overrun}, 1);

        // 5: A released at phase 1, re-pressed 10 cycles later
        notes = '0;
        wait_valid(e);
        notes = 7'b010_0000;
        repeat (6) wait_valid(e);
        check("a_phase1", $signed(sample), -AMP);
        repeat (DIV - 5) @(posedge clk);
        @(negedge clk);
        notes = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("a_released", $signed(sample), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        notes = 7'b010_0000;
        wait_valid(e);
        check("a_restart", $signed(sample), AMP);
        repeat (4) wait_valid(e);
        check("a_late_pos", $signed(sample), AMP);
        wait_valid(e);
        check("a_flip", $signed(sample), -AMP);

        // 6: reset mid-stream with all notes on
        ready = 1'b0;
        notes = 7'h7F;
        wait_valid(e);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sample",  $signed(sample), 0);
        check("arst_valid",   {31'd0, sample_valid}, 0);
        check("arst_overrun", {31'd0, overrun}, 0);
        check("arst_note_on", {31'd0, note_on}, 0);
        @(posedge clk); #2 rst = 1'b0;
        ready = 1'b1;
        wait_valid(e);
        check("post_rst_edge", e, DIV);
        check("post_rst_sample", $signed(sample), 7340032);
        check("post_rst_overrun", {31'd0, overrun}, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
